// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in, serial-out shifter. A WIDTH-bit word is accepted over a
//   valid/ready handshake and shifted out MSB first. One bit is consumed on
//   each clock edge where i_shift_enable is high. Back-to-back words are
//   accepted on the last-bit edge, so consecutive words have no gap bits.
//
// Ports
//   i_clk             rising-edge clock
//   i_reset           synchronous, active-high reset (dominates)
//   i_load_data       parallel word, sampled on handshake
//   i_load_valid      i_load_data is valid
//   o_load_ready      a word can be accepted this cycle (combinational)
//   i_shift_enable    bit-advance strobe
//   o_data_out        current serial bit (MSB of shift register)
//   o_data_out_valid  o_data_out carries a live bit
//   o_busy            a word is in flight
//   o_done            one-cycle pulse after the last bit of a word is consumed
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic             i_shift_enable,
    output logic             o_data_out,
    output logic             o_data_out_valid,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned    CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_shreg;
    logic [CW-1:0]       r_cnt;
    logic                r_done;

    state_t              w_state_nxt;
    logic [WIDTH-1:0]    w_shreg_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic                w_is_shift;
    logic                w_last;
    logic                w_ready;
    logic                w_load;

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;

        w_is_shift  = (r_state == ST_SHIFT);
        // Last bit consumed on this edge: the slot frees up immediately,
        // which is what lets the next word follow with no gap.
        w_last      = w_is_shift && i_shift_enable && (r_cnt == LAST_IDX);
        w_ready     = !w_is_shift || w_last;
        w_load      = i_load_valid && w_ready;

        // A load takes priority over the last-bit retire; a shift strobe
        // coinciding with a load from IDLE is ignored.
        if (w_load) begin
            w_shreg_nxt = i_load_data;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_SHIFT;
        end else if (w_is_shift && i_shift_enable) begin
            if (r_cnt == LAST_IDX) begin
                w_shreg_nxt = '0;
                w_state_nxt = ST_IDLE;
            end else begin
                w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
                w_cnt_nxt   = r_cnt + 1'b1;
            end
        end

        o_load_ready     = w_ready;
        o_data_out       = w_is_shift ? r_shreg[WIDTH-1] : 1'b0;
        o_data_out_valid = w_is_shift;
        o_busy           = w_is_shift;
        o_done           = r_done;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_last;
        end
    end

endmodule
